// File: rtl/atm_account_arbiter_pkg.sv
// atm_pkg: definitions shared by the account arbiter and the per-terminal
// session FSMs.
//   - operation codes carried on req_op
//   - arbiter state encoding
//   - default balance width
package atm_pkg;

  localparam int DEFAULT_BALANCE_WIDTH = 20;

  localparam logic [1:0] OP_WITHDRAW = 2'b00;
  localparam logic [1:0] OP_DEPOSIT  = 2'b01;
  localparam logic [1:0] OP_INQUIRY  = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/atm_account_arbiter_if.sv
// atm_account_arbiter_if: terminal request/response bus plus the
// bank-side provisioning port of the account arbiter.
//   master : driven by the terminals / provisioning side (req*, cfg*)
//   slave  : the arbiter (drives grant, done, error, rsp_balance, busy)
interface atm_account_arbiter_if
  import atm_pkg::*;
#(
  parameter int NUM_ATM       = 4,
  parameter int BALANCE_WIDTH = DEFAULT_BALANCE_WIDTH,
  parameter int NUM_ACCOUNTS  = 16,
  parameter int ACCT_WIDTH    = $clog2(NUM_ACCOUNTS)
);

  logic [NUM_ATM-1:0]               req;
  logic [2*NUM_ATM-1:0]             req_op;
  logic [ACCT_WIDTH*NUM_ATM-1:0]    req_acct;
  logic [BALANCE_WIDTH*NUM_ATM-1:0] req_value;

  logic                             cfg_we;
  logic [ACCT_WIDTH-1:0]            cfg_acct;
  logic [BALANCE_WIDTH-1:0]         cfg_balance;

  logic [NUM_ATM-1:0]               grant;
  logic [NUM_ATM-1:0]               done;
  logic                             error;
  logic [BALANCE_WIDTH-1:0]         rsp_balance;
  logic                             busy;

  modport master (
    output req, req_op, req_acct, req_value,
    output cfg_we, cfg_acct, cfg_balance,
    input  grant, done, error, rsp_balance, busy
  );

  modport slave (
    input  req, req_op, req_acct, req_value,
    input  cfg_we, cfg_acct, cfg_balance,
    output grant, done, error, rsp_balance, busy
  );

endinterface

// File: rtl/atm_account_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick.
//   req       : request vector, one bit per terminal
//   ptr       : terminal index where the search starts (wraps mod NUM_ATM)
//   grant     : one-hot winner (all zero when nothing is requested)
//   grant_idx : binary index of the winner
//   valid     : at least one request present
module rr_arbiter #(
  parameter  int NUM_ATM   = 4,
  localparam int PTR_WIDTH = $clog2(NUM_ATM)
) (
  input  logic [NUM_ATM-1:0]   req,
  input  logic [PTR_WIDTH-1:0] ptr,
  output logic [NUM_ATM-1:0]   grant,
  output logic [PTR_WIDTH-1:0] grant_idx,
  output logic                 valid
);

  // cand_idx[k] is the terminal checked k-th in the search, i.e. (ptr+k) mod N.
  // The sum is at most 2N-2, so a single conditional subtract wraps it.
  logic [PTR_WIDTH-1:0] cand_idx [NUM_ATM];
  logic [NUM_ATM-1:0]   rot_req;

  for (genvar gi = 0; gi < NUM_ATM; gi++) begin : g_rot
    logic [PTR_WIDTH:0] sum;
    assign sum          = {1'b0, ptr} + (PTR_WIDTH+1)'(gi);
    assign cand_idx[gi] = (sum >= (PTR_WIDTH+1)'(NUM_ATM))
                          ? PTR_WIDTH'(sum - (PTR_WIDTH+1)'(NUM_ATM))
                          : sum[PTR_WIDTH-1:0];
    assign rot_req[gi]  = req[cand_idx[gi]];
  end

  // Scan from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = NUM_ATM - 1; k >= 0; k--) begin
      if (rot_req[k]) begin
        grant_idx = cand_idx[k];
        valid     = 1'b1;
      end
    end
    grant = valid ? (NUM_ATM'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/atm_account_arbiter.sv
// atm_account_arbiter: shared account-balance store serving NUM_ATM
// terminals one at a time. Each granted request runs as an atomic
// read-modify-write through IDLE -> GRANT -> EXEC -> RESP.
//   clk, rst : clock (rising edge) and asynchronous active-high reset
//   bus      : slave side of atm_account_arbiter_if
//              (req/req_op/req_acct/req_value in, cfg_* provisioning in,
//               grant/done/error/rsp_balance/busy out)
module atm_account_arbiter
  import atm_pkg::*;
#(
  parameter int NUM_ATM       = 4,
  parameter int BALANCE_WIDTH = DEFAULT_BALANCE_WIDTH,
  parameter int NUM_ACCOUNTS  = 16,
  parameter int ACCT_WIDTH    = $clog2(NUM_ACCOUNTS)
) (
  input logic                 clk,
  input logic                 rst,
  atm_account_arbiter_if.slave bus
);

  localparam int PTR_WIDTH = $clog2(NUM_ATM);

  // Per-terminal views of the packed request operand buses.
  logic [1:0]               op_arr    [NUM_ATM];
  logic [ACCT_WIDTH-1:0]    acct_arr  [NUM_ATM];
  logic [BALANCE_WIDTH-1:0] value_arr [NUM_ATM];

  for (genvar gi = 0; gi < NUM_ATM; gi++) begin : g_unpack
    assign op_arr[gi]    = bus.req_op[gi*2 +: 2];
    assign acct_arr[gi]  = bus.req_acct[gi*ACCT_WIDTH +: ACCT_WIDTH];
    assign value_arr[gi] = bus.req_value[gi*BALANCE_WIDTH +: BALANCE_WIDTH];
  end

  // Round-robin winner among the current requests.
  logic [NUM_ATM-1:0]   win_onehot;
  logic [PTR_WIDTH-1:0] win_idx;
  logic                 win_valid;
  logic [PTR_WIDTH-1:0] ptr_reg;
  logic [PTR_WIDTH-1:0] ptr_next;

  rr_arbiter #(.NUM_ATM(NUM_ATM)) u_rr (
    .req       (bus.req),
    .ptr       (ptr_reg),
    .grant     (win_onehot),
    .grant_idx (win_idx),
    .valid     (win_valid)
  );

  assign ptr_next = (win_idx == PTR_WIDTH'(NUM_ATM - 1)) ? '0 : win_idx + 1'b1;

  // State and registered outputs.
  arb_state_t               state_reg;
  logic [NUM_ATM-1:0]       grant_reg;
  logic [NUM_ATM-1:0]       done_reg;
  logic                     error_reg;
  logic [BALANCE_WIDTH-1:0] rsp_balance_reg;

  // Transaction latched at grant time; old_reg is the balance read in GRANT.
  logic [1:0]               op_reg;
  logic [ACCT_WIDTH-1:0]    acct_reg;
  logic [BALANCE_WIDTH-1:0] value_reg;
  logic [BALANCE_WIDTH-1:0] old_reg;

  // Register-based array: reset must clear every entry, which rules out a RAM.
  logic [BALANCE_WIDTH-1:0] bal_mem [NUM_ACCOUNTS];

  // EXEC result. exec_new defaults to old so the rejected path reports old.
  logic [BALANCE_WIDTH:0]   dep_sum;
  logic [BALANCE_WIDTH-1:0] exec_new;
  logic                     exec_err;
  logic                     exec_we;

  always_comb begin
    dep_sum  = {1'b0, old_reg} + {1'b0, value_reg};
    exec_new = old_reg;
    exec_err = 1'b0;
    exec_we  = 1'b0;
    case (op_reg)
      OP_WITHDRAW: begin
        if (value_reg > old_reg) begin
          exec_err = 1'b1;
        end else begin
          exec_new = old_reg - value_reg;
          exec_we  = 1'b1;
        end
      end
      OP_DEPOSIT: begin
        if (dep_sum[BALANCE_WIDTH]) begin
          exec_err = 1'b1;
        end else begin
          exec_new = dep_sum[BALANCE_WIDTH-1:0];
          exec_we  = 1'b1;
        end
      end
      OP_INQUIRY: begin
        exec_new = old_reg;
      end
      default: begin
        exec_err = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      grant_reg       <= '0;
      done_reg        <= '0;
      error_reg       <= 1'b0;
      rsp_balance_reg <= '0;
      op_reg          <= OP_WITHDRAW;
      acct_reg        <= '0;
      value_reg       <= '0;
      old_reg         <= '0;
      for (int i = 0; i < NUM_ACCOUNTS; i++) begin
        bal_mem[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          // Provisioning takes the cycle; pending requests wait one more.
          if (bus.cfg_we) begin
            bal_mem[bus.cfg_acct] <= bus.cfg_balance;
          end else if (win_valid) begin
            grant_reg <= win_onehot;
            op_reg    <= op_arr[win_idx];
            acct_reg  <= acct_arr[win_idx];
            value_reg <= value_arr[win_idx];
            ptr_reg   <= ptr_next;
            state_reg <= GRANT;
          end
        end
        GRANT: begin
          old_reg   <= bal_mem[acct_reg];
          state_reg <= EXEC;
        end
        EXEC: begin
          if (exec_we) begin
            bal_mem[acct_reg] <= exec_new;
          end
          done_reg        <= grant_reg;
          error_reg       <= exec_err;
          rsp_balance_reg <= exec_new;
          state_reg       <= RESP;
        end
        RESP: begin
          done_reg  <= '0;
          grant_reg <= '0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.done        = done_reg;
  assign bus.error       = error_reg;
  assign bus.rsp_balance = rsp_balance_reg;
  assign bus.busy        = (state_reg != IDLE);

endmodule

// File: tb/tb_atm_account_arbiter.sv
// Directed testbench for atm_account_arbiter. Inputs change and outputs are
// sampled on the falling clock edge; expected values are hand-computed.
module tb_atm_account_arbiter;
  import atm_pkg::*;

  localparam int NUM_ATM = 4;
  localparam int BW      = 20;
  localparam int NACC    = 16;
  localparam int AW      = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  atm_account_arbiter_if #(
    .NUM_ATM(NUM_ATM), .BALANCE_WIDTH(BW), .NUM_ACCOUNTS(NACC)
  ) bus ();

  atm_account_arbiter #(
    .NUM_ATM(NUM_ATM), .BALANCE_WIDTH(BW), .NUM_ACCOUNTS(NACC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int t, input logic [1:0] op, input int acct, input int val);
    bus.req_op[t*2 +: 2]     = op;
    bus.req_acct[t*AW +: AW] = AW'(acct);
    bus.req_value[t*BW +: BW] = BW'(val);
    bus.req[t]               = 1'b1;
  endtask

  task automatic cfg_load(input int acct, input int bal);
    bus.cfg_we      = 1'b1;
    bus.cfg_acct    = AW'(acct);
    bus.cfg_balance = BW'(bal);
    @(negedge clk);
    bus.cfg_we      = 1'b0;
  endtask

  // Called at a falling edge with terminal t's request already pending and
  // t being the next round-robin winner: grant for three cycles, done in the
  // third, then back to IDLE.
  task automatic serve(input int t, input logic exp_err, input int exp_bal, input string tag);
    logic [NUM_ATM-1:0] oh;
    oh = NUM_ATM'(1) << t;
    @(negedge clk);
    check({tag, ".grant_t1"}, bus.grant, oh);
    check({tag, ".busy"}, bus.busy, 1'b1);
    @(negedge clk);
    check({tag, ".grant_t2"}, bus.grant, oh);
    check({tag, ".done_early"}, bus.done, '0);
    @(negedge clk);
    check({tag, ".grant_t3"}, bus.grant, oh);
    check({tag, ".done"}, bus.done, oh);
    check({tag, ".error"}, bus.error, exp_err);
    check({tag, ".rsp_balance"}, bus.rsp_balance, exp_bal);
    $display("txn %s term=%0d error=%0b rsp_balance=%0d", tag, t, bus.error, bus.rsp_balance);
    bus.req[t] = 1'b0;
    @(negedge clk);
    check({tag, ".done_clear"}, bus.done, '0);
    check({tag, ".idle"}, bus.busy, 1'b0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.req         = '0;
    bus.req_op      = '0;
    bus.req_acct    = '0;
    bus.req_value   = '0;
    bus.cfg_we      = 1'b0;
    bus.cfg_acct    = '0;
    bus.cfg_balance = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst.grant", bus.grant, '0);
    check("rst.done", bus.done, '0);
    check("rst.error", bus.error, 1'b0);
    check("rst.rsp_balance", bus.rsp_balance, '0);
    check("rst.busy", bus.busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Withdraw 300 from 1000
    cfg_load(3, 1000);
    set_req(0, OP_WITHDRAW, 3, 300);
    serve(0, 1'b0, 700, "wd300");

    // Overdraft rejected, balance unchanged
    set_req(1, OP_WITHDRAW, 3, 701);
    serve(1, 1'b1, 700, "wd701");
    set_req(3, OP_INQUIRY, 3, 0);
    serve(3, 1'b0, 700, "inq_after_overdraft");

    // Deposit overflow boundary
    cfg_load(5, (1 << 20) - 10);
    set_req(2, OP_DEPOSIT, 5, 10);
    serve(2, 1'b1, (1 << 20) - 10, "dep_ovf");
    set_req(2, OP_DEPOSIT, 5, 9);
    serve(2, 1'b0, (1 << 20) - 1, "dep_max");

    // Four simultaneous deposits of 1 to acct 0; ptr currently 3
    // (last grant went to terminal 2), so order 3,0,1,2 would appear.
    // Realign ptr to 0 first with a lone request from terminal 3.
    set_req(3, OP_INQUIRY, 0, 0);
    serve(3, 1'b0, 0, "inq_acct0");
    for (int k = 0; k < NUM_ATM; k++) set_req(k, OP_DEPOSIT, 0, 1);
    for (int k = 0; k < NUM_ATM; k++) serve(k, 1'b0, k + 1, "rr_dep");

    // ptr wrapped to 0: terminal 0 beats terminal 2
    set_req(0, OP_DEPOSIT, 0, 1);
    set_req(2, OP_DEPOSIT, 0, 1);
    serve(0, 1'b0, 5, "wrap_t0");
    serve(2, 1'b0, 6, "wrap_t2");

    // Illegal op, then confirm no write
    set_req(2, 2'b11, 3, 5);
    serve(2, 1'b1, 700, "illegal_op");
    set_req(1, OP_INQUIRY, 3, 0);
    serve(1, 1'b0, 700, "inq_acct3");

    // cfg_we during GRANT is ignored
    set_req(3, OP_INQUIRY, 3, 0);
    @(negedge clk);
    check("cfg_grant.grant", bus.grant, 4'b1000);
    bus.cfg_we      = 1'b1;
    bus.cfg_acct    = AW'(3);
    bus.cfg_balance = BW'(9);
    @(negedge clk);
    bus.cfg_we = 1'b0;
    @(negedge clk);
    check("cfg_grant.done", bus.done, 4'b1000);
    check("cfg_grant.rsp_balance", bus.rsp_balance, 700);
    bus.req[3] = 1'b0;
    @(negedge clk);
    set_req(0, OP_INQUIRY, 3, 0);
    serve(0, 1'b0, 700, "inq_after_cfg_grant");

    // Reset in EXEC of a withdraw aborts it and clears the array
    set_req(1, OP_WITHDRAW, 3, 100);
    @(negedge clk);
    @(negedge clk);
    check("abort.busy_exec", bus.busy, 1'b1);
    check("abort.grant_exec", bus.grant, 4'b0010);
    rst = 1'b1;
    #1;
    check("abort.grant", bus.grant, '0);
    check("abort.done", bus.done, '0);
    check("abort.error", bus.error, 1'b0);
    check("abort.rsp_balance", bus.rsp_balance, '0);
    check("abort.busy", bus.busy, 1'b0);
    bus.req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_req(0, OP_INQUIRY, 3, 0);
    serve(0, 1'b0, 0, "inq_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
